// File: rtl/fall_object_engine.sv
// Falling-object game core: farmer movement, object spawn/fall, catch scoring.
// Optional FALL_ENGINE_SPEEDUP_EN doubles the fall step once score_pos reaches 16.
module fall_object_engine #(
  parameter int unsigned STEP_PX   = 8,
  parameter int unsigned CATCH_Y   = 320,
  parameter int unsigned SPAWN_GAP = 12,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        run,
  input  logic        tick,
  input  logic        key_valid,
  input  logic [8:0]  last_change,
  input  logic        key_is_make,
  output logic [2:0]  farmer_x,
  output logic [11:0] obj_x,
  output logic [39:0] obj_y,
  output logic [3:0]  obj_active,
  output logic [5:0]  score_pos,
  output logic [5:0]  score_neg,
  output logic        catch_fruit,
  output logic        catch_bug
);

  localparam logic [8:0]  KEY_A     = 9'h01C;
  localparam logic [8:0]  KEY_D     = 9'h023;
  localparam logic [10:0] CATCH_LIM = 11'(CATCH_Y);
  localparam logic [10:0] FLOOR_LIM = 11'd480;
  localparam logic [10:0] STEP_BASE = 11'(STEP_PX);
  localparam logic [7:0]  GAP       = 8'(SPAWN_GAP);

  logic [2:0]       farmer_q, farmer_d;
  logic [3:0][2:0]  obj_x_q, obj_x_d;
  logic [3:0][9:0]  obj_y_q, obj_y_d;
  logic [3:0]       active_q, active_d;
  logic [5:0]       score_pos_q, score_pos_d;
  logic [5:0]       score_neg_q, score_neg_d;
  logic [7:0]       spawn_cnt_q, spawn_cnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             catch_fruit_q, catch_fruit_d;
  logic             catch_bug_q, catch_bug_d;

  logic [10:0] step;
  logic [10:0] next_y;
  logic [7:0]  pos_sum;
  logic [7:0]  neg_sum;
  logic [7:0]  spawn_cnt_inc;
  logic        free_found;
  logic [1:0]  free_idx;

  always_comb begin
    step = STEP_BASE;
`ifdef FALL_ENGINE_SPEEDUP_EN
    if (score_pos_q >= 6'd16) step = STEP_BASE << 1;
`endif
    lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    farmer_d      = farmer_q;
    obj_x_d       = obj_x_q;
    obj_y_d       = obj_y_q;
    active_d      = active_q;
    score_pos_d   = score_pos_q;
    score_neg_d   = score_neg_q;
    spawn_cnt_d   = spawn_cnt_q;
    catch_fruit_d = 1'b0;
    catch_bug_d   = 1'b0;
    next_y        = 11'd0;
    pos_sum       = {2'b00, score_pos_q};
    neg_sum       = {2'b00, score_neg_q};
    spawn_cnt_inc = (spawn_cnt_q >= GAP) ? GAP : spawn_cnt_q + 8'd1;
    free_found    = 1'b0;
    free_idx      = 2'd0;

    // Descending scan leaves the lowest inactive slot selected.
    for (int i = 3; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = 2'(i);
      end
    end

    if (run && tick) begin
      for (int i = 0; i < 4; i++) begin
        if (active_q[i]) begin
          next_y = {1'b0, obj_y_q[i]} + step;
          if (({1'b0, obj_y_q[i]} < CATCH_LIM) && (next_y >= CATCH_LIM)) begin
            obj_y_d[i] = next_y[9:0];
            if (obj_x_q[i] == farmer_q) begin
              active_d[i] = 1'b0;
              if (i == 0) begin
                neg_sum     = neg_sum + 8'd1;
                catch_bug_d = 1'b1;
              end else begin
                pos_sum       = pos_sum + 8'(i);
                catch_fruit_d = 1'b1;
              end
            end
          end else if (next_y >= FLOOR_LIM) begin
            active_d[i] = 1'b0;
          end else begin
            obj_y_d[i] = next_y[9:0];
          end
        end
      end
      score_pos_d = (pos_sum > 8'd63) ? 6'd63 : pos_sum[5:0];
      score_neg_d = (neg_sum > 8'd63) ? 6'd63 : neg_sum[5:0];

      spawn_cnt_d = spawn_cnt_inc;
      if ((spawn_cnt_inc == GAP) && free_found) begin
        obj_x_d[free_idx]  = lfsr_q[2:0];
        obj_y_d[free_idx]  = 10'd0;
        active_d[free_idx] = 1'b1;
        spawn_cnt_d        = 8'd0;
      end
    end

    // Collision above used farmer_q, so the move lands on the same edge.
    if (run && key_valid && key_is_make) begin
      if ((last_change == KEY_A) && (farmer_q != 3'd0)) farmer_d = farmer_q - 3'd1;
      else if ((last_change == KEY_D) && (farmer_q != 3'd7)) farmer_d = farmer_q + 3'd1;
    end

    if (clear) begin
      farmer_d      = 3'd3;
      obj_x_d       = '0;
      obj_y_d       = '0;
      active_d      = 4'd0;
      score_pos_d   = 6'd0;
      score_neg_d   = 6'd0;
      spawn_cnt_d   = 8'd0;
      catch_fruit_d = 1'b0;
      catch_bug_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      farmer_q      <= 3'd3;
      obj_x_q       <= '0;
      obj_y_q       <= '0;
      active_q      <= 4'd0;
      score_pos_q   <= 6'd0;
      score_neg_q   <= 6'd0;
      spawn_cnt_q   <= 8'd0;
      lfsr_q        <= LFSR_SEED;
      catch_fruit_q <= 1'b0;
      catch_bug_q   <= 1'b0;
    end else begin
      farmer_q      <= farmer_d;
      obj_x_q       <= obj_x_d;
      obj_y_q       <= obj_y_d;
      active_q      <= active_d;
      score_pos_q   <= score_pos_d;
      score_neg_q   <= score_neg_d;
      spawn_cnt_q   <= spawn_cnt_d;
      lfsr_q        <= lfsr_d;
      catch_fruit_q <= catch_fruit_d;
      catch_bug_q   <= catch_bug_d;
    end
  end

  assign farmer_x    = farmer_q;
  assign obj_x       = obj_x_q;
  assign obj_y       = obj_y_q;
  assign obj_active  = active_q;
  assign score_pos   = score_pos_q;
  assign score_neg   = score_neg_q;
  assign catch_fruit = catch_fruit_q;
  assign catch_bug   = catch_bug_q;

endmodule
